// File: rtl/fpga_robots_game_pkg.sv
`default_nettype none
// ============================================================================
// fpga_robots_game_pkg : cell/op codes, play-area geometry, cell I/O states
// Revision 1.0
// ============================================================================
package fpga_robots_game_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY  = 2'd0,
    CELL_ROBOT  = 2'd1,
    CELL_TRASH  = 2'd2,
    CELL_PLAYER = 2'd3
  } cell_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  localparam int PA_COLS = 120;
  localparam int PA_ROWS = 96;
  localparam int TM_ROWS = 48;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_CLR  = 3'd4,
    ST_ERR  = 3'd5
  } cellio_state_e;

endpackage
`default_nettype wire

// File: rtl/fpga_robots_game_cellio.sv
`default_nettype none
// ============================================================================
// fpga_robots_game_cellio : 2-bit cell read/modify/write and play-area clear
// Revision 1.0
// ============================================================================
module fpga_robots_game_cellio #(
  parameter int PA_COLS = fpga_robots_game_pkg::PA_COLS,
  parameter int PA_ROWS = fpga_robots_game_pkg::PA_ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [6:0]  cmd_x,
  input  logic [6:0]  cmd_y,
  input  logic [1:0]  cmd_val,
  output logic        rsp_valid,
  output logic [1:0]  rsp_val,
  output logic        rsp_err,
  output logic [12:0] tm_adr,
  output logic [7:0]  tm_wrt,
  output logic        tm_wen,
  input  logic [7:0]  tm_red
);
  import fpga_robots_game_pkg::*;

  localparam logic [6:0] LAST_COL = 7'(PA_COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(PA_ROWS / 2 - 1);

  cellio_state_e state_q, state_d;
  logic        sel_q, sel_d;
  logic [1:0]  val_q, val_d;
  logic        is_wr_q, is_wr_d;
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_val_q, rsp_val_d;
  logic        rsp_err_q, rsp_err_d;
  logic [12:0] tm_adr_q, tm_adr_d;
  logic [7:0]  tm_wrt_q, tm_wrt_d;
  logic        tm_wen_q, tm_wen_d;

  logic       accept;
  logic       in_range;
  logic [1:0] old_field;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    in_range  = (int'(cmd_x) < PA_COLS) && (int'(cmd_y) < PA_ROWS);
    old_field = sel_q ? tm_red[3:2] : tm_red[1:0];

    state_d     = state_q;
    sel_d       = sel_q;
    val_d       = val_q;
    is_wr_d     = is_wr_q;
    row_d       = row_q;
    col_d       = col_q;
    rsp_valid_d = 1'b0;
    rsp_val_d   = 2'd0;
    rsp_err_d   = 1'b0;
    tm_adr_d    = tm_adr_q;
    tm_wrt_d    = tm_wrt_q;
    tm_wen_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sel_d   = cmd_y[0];
          val_d   = cmd_val;
          is_wr_d = (cmd_op == OP_WRITE);
          row_d   = 6'd0;
          col_d   = 7'd0;
          if (cmd_op == OP_CLEAR) begin
            state_d = ST_CLR;
          end else if (cmd_op == OP_RSVD || !in_range) begin
            state_d = ST_ERR;
          end else begin
            state_d  = ST_RD;
            tm_adr_d = {cmd_y[6:1], cmd_x};
          end
        end
      end
      ST_RD: state_d = ST_WAIT;
      ST_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_val_d   = old_field;
        if (is_wr_q) begin
          state_d  = ST_WR;
          tm_wen_d = 1'b1;
          // Only the addressed cell changes; the neighbour and bits [7:4] ride along.
          tm_wrt_d = sel_q ? {tm_red[7:4], val_q, tm_red[1:0]}
                           : {tm_red[7:2], val_q};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_CLR: begin
        tm_adr_d = {row_q, col_q};
        tm_wrt_d = 8'h00;
        tm_wen_d = 1'b1;
        if (col_q == LAST_COL) begin
          col_d = 7'd0;
          if (row_q == LAST_ROW) begin
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            row_d = row_q + 6'd1;
          end
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      ST_ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      val_q       <= 2'd0;
      is_wr_q     <= 1'b0;
      row_q       <= 6'd0;
      col_q       <= 7'd0;
      rsp_valid_q <= 1'b0;
      rsp_val_q   <= 2'd0;
      rsp_err_q   <= 1'b0;
      tm_adr_q    <= 13'd0;
      tm_wrt_q    <= 8'd0;
      tm_wen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      val_q       <= val_d;
      is_wr_q     <= is_wr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_val_q   <= rsp_val_d;
      rsp_err_q   <= rsp_err_d;
      tm_adr_q    <= tm_adr_d;
      tm_wrt_q    <= tm_wrt_d;
      tm_wen_q    <= tm_wen_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_val   = rsp_val_q;
  assign rsp_err   = rsp_err_q;
  assign tm_adr    = tm_adr_q;
  assign tm_wrt    = tm_wrt_q;
  assign tm_wen    = tm_wen_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga_robots_game_cellio.sv
`default_nettype none
// ============================================================================
// tb_fpga_robots_game_cellio : randomized bench with tile-map memory and cell model
// Revision 1.0
// ============================================================================
module tb_fpga_robots_game_cellio;

  localparam int COLS       = 120;
  localparam int ROWS       = 96;
  localparam int CLR_WRITES = 48 * COLS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [6:0]  cmd_x = 7'd0;
  logic [6:0]  cmd_y = 7'd0;
  logic [1:0]  cmd_val = 2'd0;
  logic        rsp_valid;
  logic [1:0]  rsp_val;
  logic        rsp_err;
  logic [12:0] tm_adr;
  logic [7:0]  tm_wrt;
  logic        tm_wen;
  logic [7:0]  tm_red;

  always #5 clk = ~clk;

  fpga_robots_game_cellio #(.PA_COLS(COLS), .PA_ROWS(ROWS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_val(cmd_val),
    .rsp_valid(rsp_valid), .rsp_val(rsp_val), .rsp_err(rsp_err),
    .tm_adr(tm_adr), .tm_wrt(tm_wrt), .tm_wen(tm_wen), .tm_red(tm_red)
  );

  // Tile map: synchronous read, plus a backdoor for preloading
  logic [7:0]  mem [0:8191];
  logic [7:0]  red_q;
  logic        bd_fill = 1'b0;
  logic        bd_we = 1'b0;
  logic [12:0] bd_adr = 13'd0;
  logic [7:0]  bd_dat = 8'd0;
  int          bd_mul = 0;
  int          bd_add = 0;

  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'(i * bd_mul + bd_add);
    end else if (bd_we) begin
      mem[bd_adr] <= bd_dat;
    end else if (tm_wen) begin
      mem[tm_adr] <= tm_wrt;
    end
    red_q <= mem[tm_adr];
  end
  assign tm_red = red_q;

  int          wen_cnt = 0;
  int          rsp_cnt = 0;
  logic [12:0] last_wen_adr = 13'd0;
  logic [7:0]  last_wen_dat = 8'd0;

  always @(posedge clk) begin
    if (tm_wen) begin
      wen_cnt++;
      last_wen_adr = tm_adr;
      last_wen_dat = tm_wrt;
    end
    if (rsp_valid) rsp_cnt++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference model: byte image plus cell arithmetic on it
  logic [7:0] ref_mem [0:8191];

  function automatic int cell_adr(input int x, input int y);
    return (y / 2) * 128 + x;
  endfunction

  function automatic int cell_get(input int x, input int y);
    return (int'(ref_mem[cell_adr(x, y)]) >> ((y % 2) * 2)) % 4;
  endfunction

  function automatic void cell_set(input int x, input int y, input int v);
    int a;
    int sh;
    int b;
    a  = cell_adr(x, y);
    sh = (y % 2) * 2;
    b  = int'(ref_mem[a]);
    b  = b - (((b >> sh) % 4) << sh) + (v << sh);
    ref_mem[a] = 8'(b);
  endfunction

  task automatic fill(input int mul, input int add);
    @(negedge clk);
    bd_mul  = mul;
    bd_add  = add;
    bd_fill = 1'b1;
    @(negedge clk);
    bd_fill = 1'b0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i * mul + add);
  endtask

  task automatic poke(input int adr, input logic [7:0] d);
    @(negedge clk);
    bd_adr = 13'(adr);
    bd_dat = d;
    bd_we  = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[adr] = d;
  endtask

  task automatic do_cmd(input int op, input int x, input int y, input int v,
                        output int rv, output int re, output int lat, output int busy_ready);
    int n;
    @(negedge clk);
    cmd_op    = 2'(op);
    cmd_x     = 7'(x);
    cmd_y     = 7'(y);
    cmd_val   = 2'(v);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", int'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    rv = 0;
    re = 0;
    busy_ready = 0;
    while (lat < 10000) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid) begin
        rv = int'(rsp_val);
        re = int'(rsp_err);
        break;
      end
      if (cmd_ready) busy_ready++;
    end
    check("rsp_seen", int'(rsp_valid), 1);
  endtask

  int rv, re, lat, br, wen0, rsp0, bad, r, op, x, y, v, exp_rv, n;
  int bx [8];
  int by [8];
  time t_acc, t_prev;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_err", int'(rsp_err), 0);
    check("rst_rsp_val", int'(rsp_val), 0);
    check("rst_tm_adr", int'(tm_adr), 0);
    check("rst_tm_wrt", int'(tm_wrt), 0);
    check("rst_tm_wen", int'(tm_wen), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_ready", int'(cmd_ready), 1);

    // Directed read and write of the known byte
    fill(0, 0);
    poke(13'h1A5, 8'hB6);
    do_cmd(0, 37, 7, 0, rv, re, lat, br);
    check("rd_val", rv, 1);
    check("rd_model", rv, cell_get(37, 7));
    check("rd_err", re, 0);
    check("rd_lat", lat, 2);

    wen0 = wen_cnt;
    do_cmd(1, 37, 6, 3, rv, re, lat, br);
    repeat (2) @(posedge clk);
    #1;
    check("wr_old", rv, 2);
    check("wr_err", re, 0);
    check("wr_wen_n", wen_cnt - wen0, 1);
    check("wr_adr", int'(last_wen_adr), 'h1A5);
    check("wr_dat", int'(last_wen_dat), 'hB7);
    cell_set(37, 6, 3);
    do_cmd(0, 37, 6, 0, rv, re, lat, br);
    check("wr_readback", rv, 3);

    // Error commands
    wen0 = wen_cnt;
    do_cmd(0, 120, 0, 0, rv, re, lat, br);
    check("err_x_err", re, 1);
    check("err_x_lat", lat, 1);
    check("err_x_val", rv, 0);
    do_cmd(3, 5, 5, 2, rv, re, lat, br);
    check("err_op_err", re, 1);
    check("err_op_lat", lat, 1);
    do_cmd(1, 0, 96, 1, rv, re, lat, br);
    check("err_y_err", re, 1);
    repeat (2) @(posedge clk);
    #1 check("err_no_wen", wen_cnt - wen0, 0);

    // Randomized read/write/reserved traffic against the cell model
    fill(int'($urandom_range(0, 127)) * 2 + 1, int'($urandom_range(0, 255)));
    for (int k = 0; k < 150; k++) begin
      r  = int'($urandom_range(0, 9));
      op = (r < 5) ? 0 : ((r < 9) ? 1 : 3);
      x  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(120, 127)) : int'($urandom_range(0, 119));
      y  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(96, 127)) : int'($urandom_range(0, 95));
      v  = int'($urandom_range(0, 3));
      bad = (op == 3 || x >= COLS || y >= ROWS) ? 1 : 0;
      exp_rv = (bad != 0) ? 0 : cell_get(x, y);
      wen0 = wen_cnt;
      do_cmd(op, x, y, v, rv, re, lat, br);
      repeat (2) @(posedge clk);
      #1;
      check("rnd_err", re, bad);
      check("rnd_val", rv, exp_rv);
      check("rnd_lat", lat, (bad != 0) ? 1 : 2);
      if (bad == 0 && op == 1) begin
        cell_set(x, y, v);
        check("rnd_wen_n", wen_cnt - wen0, 1);
        check("rnd_wen_adr", int'(last_wen_adr), cell_adr(x, y));
        check("rnd_wen_dat", int'(last_wen_dat), int'(ref_mem[cell_adr(x, y)]));
      end else begin
        check("rnd_no_wen", wen_cnt - wen0, 0);
      end
    end
    bad = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("rnd_mem_image", bad, 0);

    // Clear of a memory full of 0xFF
    fill(0, 255);
    wen0 = wen_cnt;
    rsp0 = rsp_cnt;
    do_cmd(2, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), int'($urandom_range(0, 3)), rv, re, lat, br);
    check("clr_lat", lat, CLR_WRITES);
    check("clr_err", re, 0);
    check("clr_val", rv, 0);
    check("clr_busy_ready", br, 0);
    repeat (3) @(posedge clk);
    #1;
    check("clr_writes", wen_cnt - wen0, CLR_WRITES);
    check("clr_rsp_count", rsp_cnt - rsp0, 1);
    check("clr_wen_idle", int'(tm_wen), 0);
    bad = 0;
    for (int i = 0; i < 8192; i++) begin
      ref_mem[i] = ((i / 128) < 48 && (i % 128) < COLS) ? 8'h00 : 8'hFF;
      if (mem[i] !== ref_mem[i]) bad++;
    end
    check("clr_mem_image", bad, 0);
    check("clr_status_byte", int'(mem[13'h0F8]), 'hFF);
    do_cmd(0, 119, 95, 0, rv, re, lat, br);
    check("clr_readback", rv, 0);

    // Back-to-back reads with cmd_valid held high
    fill(int'($urandom_range(0, 127)) * 2 + 1, int'($urandom_range(0, 255)));
    for (int k = 0; k < 8; k++) begin
      bx[k] = int'($urandom_range(0, 119));
      by[k] = int'($urandom_range(0, 95));
    end
    wen0 = wen_cnt;
    rsp0 = rsp_cnt;
    @(negedge clk);
    cmd_op    = 2'd0;
    cmd_x     = 7'(bx[0]);
    cmd_y     = 7'(by[0]);
    cmd_val   = 2'd3;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    t_prev = 0;
    for (int k = 0; k < 8; k++) begin
      check("b2b_ready", int'(cmd_ready), 1);
      @(posedge clk);
      t_acc = $time;
      if (k > 0) check("b2b_gap", int'(t_acc - t_prev), 30);
      t_prev = t_acc;
      @(posedge clk);
      #1;
      check("b2b_busy", int'(cmd_ready), 0);
      check("b2b_early", int'(rsp_valid), 0);
      @(posedge clk);
      #1;
      check("b2b_rsp", int'(rsp_valid), 1);
      check("b2b_val", int'(rsp_val), cell_get(bx[k], by[k]));
      if (k < 7) begin
        cmd_x = 7'(bx[k + 1]);
        cmd_y = 7'(by[k + 1]);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("b2b_rsp_count", rsp_cnt - rsp0, 8);
    check("b2b_no_wen", wen_cnt - wen0, 0);

    // Reset in the middle of a clear
    fill(0, 255);
    @(negedge clk);
    cmd_op    = 2'd2;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    rsp0 = rsp_cnt;
    @(posedge clk);
    #1;
    check("abort_wen", int'(tm_wen), 0);
    check("abort_rsp", int'(rsp_valid), 0);
    check("abort_ready_in_rst", int'(cmd_ready), 0);
    wen0 = wen_cnt;
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort_ready_after", int'(cmd_ready), 1);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_writes", wen_cnt - wen0, 0);
    check("abort_no_rsp", rsp_cnt - rsp0, 0);
    check("abort_first_cleared", int'(mem[0]), 0);
    check("abort_untouched", int'(mem[200]), 'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpga_robots_game_cellio.md
FPGA_ROBOTS_GAME_CELLIO -- requirements
Module: fpga_robots_game_cellio

Interface
REQ-001 SHALL have parameter PA_COLS, default 120: number of play-area byte columns; x >= PA_COLS is out of range.
REQ-002 SHALL have parameter PA_ROWS, default 96: number of play-area cell rows; y >= PA_ROWS is out of range.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset: synchronous, active-high.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  block can accept a command; high only in IDLE.
REQ-007 cmd_op  in  2  command: 0 read cell, 1 write cell, 2 clear play area, 3 reserved.
REQ-008 cmd_x  in  7  cell column, 0-119.
REQ-009 cmd_y  in  7  cell row, 0-95.
REQ-010 cmd_val  in  2  cell code to write: 0 empty, 1 robot, 2 trash, 3 player.
REQ-011 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-012 rsp_val  out  2  cell contents before the command; 0 for clear and error.
REQ-013 rsp_err  out  1  qualifies rsp_valid; command rejected, no memory access.
REQ-014 tm_adr  out  13  tile map byte address, registered.
REQ-015 tm_wrt  out  8  tile map write data, registered.
REQ-016 tm_wen  out  1  tile map write enable, registered.
REQ-017 tm_red  in  8  tile map read data, valid one clock after tm_adr is presented.

Function
REQ-018 Handshake: a command SHALL be accepted on an edge where cmd_valid && cmd_ready; the command fields SHALL be captured on that edge (E0).
REQ-019 Byte address SHALL be {cmd_y[6:1], cmd_x[6:0]}; cmd_y[0]=0 SHALL select bits [1:0] and cmd_y[0]=1 SHALL select bits [3:2].
REQ-020 States SHALL be IDLE, RD, WAIT, WR, CLR and ERR.
REQ-021 On accepting a read or write, the block SHALL go IDLE->RD and present tm_adr after E0 with tm_wen=0; RD->WAIT at E1; it SHALL sample tm_red at E2.
REQ-022 Read: at E2 the block SHALL go WAIT->IDLE and pulse rsp_valid=1, rsp_err=0, with rsp_val = the selected 2-bit field; latency from acceptance is 2 cycles.
REQ-023 Write: at E2 the block SHALL go WAIT->WR, drive tm_wen=1 and drive tm_wrt = tm_red with only the selected field replaced by cmd_val; bits [7:4] and the other cell SHALL be preserved.
REQ-024 Write: rsp_valid SHALL pulse at E2 with rsp_val = the old field; WR->IDLE at E3, and tm_wen SHALL drop after E3.
REQ-025 Clear: the block SHALL go IDLE->CLR and write 0x00 to every byte with row 0-47 and column 0..PA_COLS-1, one per cycle, in row-major order; status columns PA_COLS-127 SHALL NOT be written.
REQ-026 Clear SHALL take exactly 48*PA_COLS write cycles, i.e. 5760 for the defaults.
REQ-027 Clear: rsp_valid SHALL pulse on the edge that issues the final write (address {6'd47, 7'd119}); CLR->IDLE on that edge.
REQ-028 Out-of-range x or y on a read/write, or op 3: IDLE->ERR; rsp_valid=1, rsp_err=1, rsp_val=0 after E1; tm_wen SHALL stay 0; ERR->IDLE.
REQ-029 Clear SHALL ignore cmd_x, cmd_y and cmd_val.
REQ-030 cmd_ready SHALL be 0 in all non-IDLE states; cmd_valid arriving while busy SHALL NOT be captured.
REQ-031 A new command SHALL be acceptable on the edge after rsp_valid.
REQ-032 Outside WR and CLR, tm_wen SHALL be 0.

Reset
REQ-033 On rst: state IDLE, cmd_ready=0 during rst and 1 on the first cycle after, rsp_valid=0, rsp_err=0, rsp_val=0, tm_adr=0, tm_wrt=0, tm_wen=0.
REQ-034 rst during RD, WAIT, WR or CLR SHALL abort the operation: no further writes, tm_wen=0 the cycle after the rst edge, and no response.

Structure
REQ-035 Shared package fpga_robots_game_pkg SHALL hold:
- cell codes CELL_EMPTY/ROBOT/TRASH/PLAYER (0-3);
- op codes OP_READ/WRITE/CLEAR;
- constants PA_COLS=120, PA_ROWS=96, TM_ROWS=48.
REQ-036 Single module; no sub-module; the clear sweep counter SHALL be inline (row 6 bits, column 7 bits).

Verification
REQ-037 Preload byte 0x1A5 = 0xB6; read x=37, y=7 -> rsp_val=1 exactly 2 cycles after acceptance, rsp_err=0.
REQ-038 Preload byte 0x1A5 = 0xB6; write x=37, y=6, val=3 -> one tm_wen pulse to 0x1A5 with data 0xB7; rsp_val=2; following read of y=6 returns 3.
REQ-039 Read x=120, y=0 and op 3 -> rsp_err=1 after 1 cycle; no tm_wen.
REQ-040 Fill memory with 0xFF, clear -> 5760 write cycles; bytes with col<120 = 0x00, bytes with col 120-127 = 0xFF; single rsp_valid; cmd_ready low throughout.
REQ-041 Assert rst at clear cycle 100 -> tm_wen=0 next cycle, no rsp_valid, cmd_ready=1 after rst releases.
REQ-042 cmd_valid held high continuously with back-to-back reads -> accepted every 3 cycles; no command lost or duplicated.
